// File: rtl/wb_commit_unit_if.sv
// EX/WB segment contents, data-bus read response and register-file write port
// seen by wb_commit_unit; master drives the segment/bus side, slave is the unit.
interface wb_commit_unit_if;
  logic        stall;
  logic        refresh;
  logic [31:0] wb_pc;
  logic [31:0] wb_res;
  logic        wb_load;
  logic        wb_loadX;
  logic [3:0]  wb_lsV;
  logic [31:0] wb_data_addr;
  logic        wb_al;
  logic        wb_regwen;
  logic [4:0]  wb_wreg;
  logic        wb_cp0ren;
  logic [31:0] wb_cp0rdata;
  logic [1:0]  wb_hiloren;
  logic [31:0] wb_hilordata;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_stall_req;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output stall, refresh, wb_pc, wb_res, wb_load, wb_loadX, wb_lsV,
           wb_data_addr, wb_al, wb_regwen, wb_wreg, wb_cp0ren, wb_cp0rdata,
           wb_hiloren, wb_hilordata, data_data_ok, data_rdata,
    input  wb_stall_req, rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  stall, refresh, wb_pc, wb_res, wb_load, wb_loadX, wb_lsV,
           wb_data_addr, wb_al, wb_regwen, wb_wreg, wb_cp0ren, wb_cp0rdata,
           wb_hiloren, wb_hilordata, data_data_ok, data_rdata,
    output wb_stall_req, rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Write-back commit: result select, load alignment, read-response wait and one-write-per-instruction guard.
// Optional macro WB_COMMIT_TRACE_EN adds registered debug_wb_* trace outputs.
module wb_commit_unit (
  input  logic              clk,
  input  logic              resetn,
  wb_commit_unit_if.slave   bus
`ifdef WB_COMMIT_TRACE_EN
  ,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

  state_t      state;
  logic        committed;
  logic [31:0] buffer;

  logic        bypass;
  logic [31:0] raw_src;
  logic [31:0] raw;
  logic [4:0]  shamt;
  logic [31:0] load_val;
  logic [31:0] result;
  logic        ready;
  logic        wen;
  logic        addr_unused;

  assign addr_unused = ^bus.wb_data_addr[31:2];

  // A response seen in IDLE is the zero-latency case and is forwarded just like one seen in WAIT.
  assign bypass  = bus.data_data_ok & ((state == IDLE) | (state == WAIT));
  assign raw_src = bypass ? bus.data_rdata : buffer;
  assign shamt   = {bus.wb_data_addr[1:0], 3'b000};
  assign raw     = raw_src >> shamt;

  always_comb begin
    load_val = raw;
    case (bus.wb_lsV)
      4'b0001: load_val = {{24{bus.wb_loadX & raw[7]}}, raw[7:0]};
      4'b0011: load_val = {{16{bus.wb_loadX & raw[15]}}, raw[15:0]};
      default: load_val = raw;
    endcase
  end

  always_comb begin
    result = bus.wb_res;
    if (bus.wb_load)
      result = load_val;
    else if (bus.wb_al)
      result = bus.wb_pc + 32'd8;
    else if (bus.wb_cp0ren)
      result = bus.wb_cp0rdata;
    else if (bus.wb_hiloren != 2'b00)
      result = bus.wb_hilordata;
  end

  assign ready = ~bus.wb_load | bypass | (state == HOLD);
  assign wen   = bus.wb_regwen & ready & ~committed & (bus.wb_wreg != 5'd0)
               & (state != DROP);

  assign bus.rf_wen   = wen;
  assign bus.rf_waddr = bus.wb_wreg;
  assign bus.rf_wdata = result;

  // An uncommitted load in IDLE must already hold the pipeline, otherwise it would leave WB unwritten.
  assign bus.wb_stall_req =
      ((state == IDLE) & bus.wb_load & ~committed & ~bus.data_data_ok)
    | ((state == WAIT) & ~bus.data_data_ok)
    |  (state == DROP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      committed <= 1'b0;
      buffer    <= 32'd0;
    end else begin
      if (bypass)
        buffer <= bus.data_rdata;

      if (~bus.stall | bus.refresh)
        committed <= 1'b0;
      else if (wen)
        committed <= 1'b1;

      case (state)
        IDLE: if (bus.wb_load & ~committed & ~bus.data_data_ok) state <= WAIT;
        WAIT: begin
          if (bus.data_data_ok)
            state <= (bus.stall & ~bus.refresh) ? HOLD : IDLE;
          else if (bus.refresh)
            state <= DROP;
        end
        HOLD: if (~bus.stall | bus.refresh) state <= IDLE;
        DROP: if (bus.data_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_COMMIT_TRACE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      debug_wb_pc       <= 32'd0;
      debug_wb_rf_wen   <= 4'd0;
      debug_wb_rf_wnum  <= 5'd0;
      debug_wb_rf_wdata <= 32'd0;
    end else begin
      debug_wb_pc       <= bus.wb_pc;
      debug_wb_rf_wen   <= {4{wen}};
      debug_wb_rf_wnum  <= bus.wb_wreg;
      debug_wb_rf_wdata <= result;
    end
  end
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: single-cycle vector table plus multi-cycle load sequences.
module tb_wb_commit_unit;

  localparam logic [31:0] CP0_DATA  = 32'hC0C0_0001;
  localparam logic [31:0] HILO_DATA = 32'h4141_0002;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] res;
    logic        load;
    logic        loadx;
    logic [3:0]  lsv;
    logic [1:0]  addr;
    logic        al;
    logic        regwen;
    logic [4:0]  wreg;
    logic        cp0ren;
    logic [1:0]  hiloren;
    logic        ok;
    logic [31:0] rdata;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic        exp_stall;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fails;

  wb_commit_unit_if bus();

`ifdef WB_COMMIT_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  wb_commit_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef WB_COMMIT_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveInputs(input vec_t v, input logic stall_i, input logic refresh_i);
    bus.stall        = stall_i;
    bus.refresh      = refresh_i;
    bus.wb_pc        = v.pc;
    bus.wb_res       = v.res;
    bus.wb_load      = v.load;
    bus.wb_loadX     = v.loadx;
    bus.wb_lsV       = v.lsv;
    bus.wb_data_addr = {30'h0000_0400, v.addr};
    bus.wb_al        = v.al;
    bus.wb_regwen    = v.regwen;
    bus.wb_wreg      = v.wreg;
    bus.wb_cp0ren    = v.cp0ren;
    bus.wb_cp0rdata  = CP0_DATA;
    bus.wb_hiloren   = v.hiloren;
    bus.wb_hilordata = HILO_DATA;
    bus.data_data_ok = v.ok;
    bus.data_rdata   = v.rdata;
  endtask

  // One WB cycle: drive just after the edge, leave outputs to be sampled on the falling edge.
  task automatic applyStimulus(input vec_t v, input logic stall_i, input logic refresh_i);
    @(posedge clk);
    #1;
    driveInputs(v, stall_i, refresh_i);
    @(negedge clk);
  endtask

  vec_t vecs[13];
  vec_t nop;
  vec_t v;
  int   writes;
  logic [31:0] prev_pc;
  logic        prev_wen;
  logic [4:0]  prev_wreg;
  logic [31:0] prev_wdata;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    nop = '{"nop", 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 5'd0,
            1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};

    //          name     pc            res           ld lx lsv   ad al rw wreg  c0 hl    ok rdata          wen wdata          stl
    vecs[0]  = '{"add",   32'h0000_0100, 32'h0000_1234, 0, 0, 4'h0, 0, 0, 1, 5'd5,  0, 2'b00, 0, 32'h0,         1, 32'h0000_1234, 0};
    vecs[1]  = '{"jal",   32'h0000_1000, 32'h0000_9999, 0, 0, 4'h0, 0, 1, 1, 5'd31, 0, 2'b00, 0, 32'h0,         1, 32'h0000_1008, 0};
    vecs[2]  = '{"mfc0",  32'h0000_1004, 32'h0000_0009, 0, 0, 4'h0, 0, 0, 1, 5'd3,  1, 2'b00, 0, 32'h0,         1, 32'hC0C0_0001, 0};
    vecs[3]  = '{"mfhi",  32'h0000_1008, 32'h0000_0009, 0, 0, 4'h0, 0, 0, 1, 5'd4,  0, 2'b10, 0, 32'h0,         1, 32'h4141_0002, 0};
    vecs[4]  = '{"prio",  32'h0000_2000, 32'h0000_0009, 0, 0, 4'h0, 0, 1, 1, 5'd6,  1, 2'b01, 0, 32'h0,         1, 32'h0000_2008, 0};
    vecs[5]  = '{"lbu1",  32'h0000_2004, 32'h0000_0401, 1, 0, 4'h1, 1, 0, 1, 5'd8,  0, 2'b00, 1, 32'h1234_8678, 1, 32'h0000_0086, 0};
    vecs[6]  = '{"lb3",   32'h0000_2008, 32'h0000_0403, 1, 1, 4'h1, 3, 0, 1, 5'd9,  0, 2'b00, 1, 32'h8011_2233, 1, 32'hFFFF_FF80, 0};
    vecs[7]  = '{"lh0",   32'h0000_200C, 32'h0000_0400, 1, 1, 4'h3, 0, 0, 1, 5'd10, 0, 2'b00, 1, 32'h0000_9ABC, 1, 32'hFFFF_9ABC, 0};
    vecs[8]  = '{"lh2",   32'h0000_2010, 32'h0000_0402, 1, 1, 4'h3, 2, 0, 1, 5'd11, 0, 2'b00, 1, 32'h7FFF_0000, 1, 32'h0000_7FFF, 0};
    vecs[9]  = '{"lw",    32'h0000_2014, 32'h0000_0400, 1, 0, 4'hF, 0, 0, 1, 5'd12, 0, 2'b00, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0};
    vecs[10] = '{"lbu0",  32'h0000_2018, 32'h0000_0400, 1, 0, 4'h1, 0, 0, 1, 5'd13, 0, 2'b00, 1, 32'h0000_00FF, 1, 32'h0000_00FF, 0};
    vecs[11] = '{"r0",    32'h0000_201C, 32'h0000_0055, 0, 0, 4'h0, 0, 0, 1, 5'd0,  0, 2'b00, 0, 32'h0,         0, 32'h0000_0055, 0};
    vecs[12] = '{"nowen", 32'h0000_2020, 32'h0000_0066, 0, 0, 4'h0, 0, 0, 0, 5'd14, 0, 2'b00, 0, 32'h0,         0, 32'h0000_0066, 0};

    resetn = 1'b0;
    driveInputs(nop, 1'b0, 1'b0);
    #3;
    checkOutput("reset_stall_req", {31'd0, bus.wb_stall_req}, 32'd0);
    checkOutput("reset_rf_wen",    {31'd0, bus.rf_wen},       32'd0);
    checkOutput("reset_rf_waddr",  {27'd0, bus.rf_waddr},     32'd0);
    checkOutput("reset_rf_wdata",  bus.rf_wdata,              32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    prev_pc = 32'd0; prev_wen = 1'b0; prev_wreg = 5'd0; prev_wdata = 32'd0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], 1'b0, 1'b0);
      checkOutput({vecs[i].name, "_wen"},   {31'd0, bus.rf_wen},       {31'd0, vecs[i].exp_wen});
      checkOutput({vecs[i].name, "_wdata"}, bus.rf_wdata,              vecs[i].exp_wdata);
      checkOutput({vecs[i].name, "_waddr"}, {27'd0, bus.rf_waddr},     {27'd0, vecs[i].wreg});
      checkOutput({vecs[i].name, "_stall"}, {31'd0, bus.wb_stall_req}, {31'd0, vecs[i].exp_stall});
`ifdef WB_COMMIT_TRACE_EN
      checkOutput({vecs[i].name, "_trace_pc"},    debug_wb_pc,               prev_pc);
      checkOutput({vecs[i].name, "_trace_wen"},   {28'd0, debug_wb_rf_wen},  {28'd0, {4{prev_wen}}});
      checkOutput({vecs[i].name, "_trace_wnum"},  {27'd0, debug_wb_rf_wnum}, {27'd0, prev_wreg});
      checkOutput({vecs[i].name, "_trace_wdata"}, debug_wb_rf_wdata,         prev_wdata);
`endif
      prev_pc = vecs[i].pc; prev_wen = vecs[i].exp_wen;
      prev_wreg = vecs[i].wreg; prev_wdata = vecs[i].exp_wdata;
    end

    // lb sign-extended from lane 2, response three cycles late.
    v = nop; v.pc = 32'h0000_3000; v.load = 1; v.loadx = 1; v.lsv = 4'h1; v.addr = 2;
    v.regwen = 1; v.wreg = 5'd17; v.rdata = 32'hFFFF_FFFF;
    writes = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(v, 1'b1, 1'b0);
      checkOutput("lb_late_stall_req", {31'd0, bus.wb_stall_req}, 32'd1);
      writes += int'(bus.rf_wen);
    end
    v.ok = 1; v.rdata = 32'h0080_FF00;
    applyStimulus(v, 1'b0, 1'b0);
    checkOutput("lb_late_stall_rel", {31'd0, bus.wb_stall_req}, 32'd0);
    checkOutput("lb_late_wdata",     bus.rf_wdata,              32'hFFFF_FF80);
    writes += int'(bus.rf_wen);
    applyStimulus(nop, 1'b0, 1'b0);
    writes += int'(bus.rf_wen);
    checkOutput("lb_late_writes", writes, 32'd1);

    // lhu with the pipeline held four cycles after the response.
    v = nop; v.pc = 32'h0000_3100; v.load = 1; v.lsv = 4'h3; v.addr = 2;
    v.regwen = 1; v.wreg = 5'd18;
    applyStimulus(v, 1'b1, 1'b0);
    checkOutput("lhu_wait_stall_req", {31'd0, bus.wb_stall_req}, 32'd1);
    v.ok = 1; v.rdata = 32'hBEEF_0000;
    applyStimulus(v, 1'b1, 1'b0);
    checkOutput("lhu_commit_wen",   {31'd0, bus.rf_wen}, 32'd1);
    checkOutput("lhu_commit_wdata", bus.rf_wdata,        32'h0000_BEEF);
    v.ok = 0; v.rdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(v, 1'b1, 1'b0);
      checkOutput("lhu_hold_wen",       {31'd0, bus.rf_wen},       32'd0);
      checkOutput("lhu_hold_stall_req", {31'd0, bus.wb_stall_req}, 32'd0);
      checkOutput("lhu_hold_wdata",     bus.rf_wdata,              32'h0000_BEEF);
    end
    applyStimulus(v, 1'b0, 1'b0);
    checkOutput("lhu_release_wen", {31'd0, bus.rf_wen}, 32'd0);
    applyStimulus(vecs[0], 1'b0, 1'b0);
    checkOutput("lhu_next_add_wen", {31'd0, bus.rf_wen}, 32'd1);

    // Flush during WAIT: the stale response is dropped, the next lw takes the second one.
    v = nop; v.pc = 32'h0000_3200; v.load = 1; v.lsv = 4'hF; v.regwen = 1; v.wreg = 5'd19;
    applyStimulus(v, 1'b1, 1'b0);
    applyStimulus(v, 1'b1, 1'b1);
    checkOutput("flush_wait_stall_req", {31'd0, bus.wb_stall_req}, 32'd1);
    checkOutput("flush_wait_wen",       {31'd0, bus.rf_wen},       32'd0);
    v.pc = 32'h0000_3300; v.wreg = 5'd20; v.ok = 1; v.rdata = 32'h0000_AAAA;
    applyStimulus(v, 1'b1, 1'b0);
    checkOutput("drop_stall_req", {31'd0, bus.wb_stall_req}, 32'd1);
    checkOutput("drop_wen",       {31'd0, bus.rf_wen},       32'd0);
    v.ok = 0; v.rdata = 32'h0;
    applyStimulus(v, 1'b1, 1'b0);
    checkOutput("refill_stall_req", {31'd0, bus.wb_stall_req}, 32'd1);
    checkOutput("refill_wen",       {31'd0, bus.rf_wen},       32'd0);
    v.ok = 1; v.rdata = 32'h0000_5555;
    applyStimulus(v, 1'b0, 1'b0);
    checkOutput("refill_commit_wen",   {31'd0, bus.rf_wen},   32'd1);
    checkOutput("refill_commit_waddr", {27'd0, bus.rf_waddr}, 32'd20);
    checkOutput("refill_commit_wdata", bus.rf_wdata,          32'h0000_5555);

    // Loads that write nothing still wait for their response.
    for (int j = 0; j < 2; j++) begin
      v = nop; v.pc = 32'h0000_3400; v.load = 1; v.lsv = 4'hF;
      v.regwen = (j == 0); v.wreg = (j == 0) ? 5'd0 : 5'd21;
      applyStimulus(v, 1'b1, 1'b0);
      checkOutput("nowr_load_stall0", {31'd0, bus.wb_stall_req}, 32'd1);
      applyStimulus(v, 1'b1, 1'b0);
      checkOutput("nowr_load_stall1", {31'd0, bus.wb_stall_req}, 32'd1);
      v.ok = 1; v.rdata = 32'h0BAD_0BAD;
      applyStimulus(v, 1'b0, 1'b0);
      checkOutput("nowr_load_stall_rel", {31'd0, bus.wb_stall_req}, 32'd0);
      checkOutput("nowr_load_wen",       {31'd0, bus.rf_wen},       32'd0);
    end

    // Asynchronous reset while a load is outstanding.
    v = nop; v.pc = 32'h0000_5000; v.load = 1; v.lsv = 4'hF; v.regwen = 1; v.wreg = 5'd22;
    applyStimulus(v, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    driveInputs(nop, 1'b0, 1'b0);
    #1;
    checkOutput("async_rst_stall_req", {31'd0, bus.wb_stall_req}, 32'd0);
    checkOutput("async_rst_wen",       {31'd0, bus.rf_wen},       32'd0);
    checkOutput("async_rst_waddr",     {27'd0, bus.rf_waddr},     32'd0);
    checkOutput("async_rst_wdata",     bus.rf_wdata,              32'd0);
`ifdef WB_COMMIT_TRACE_EN
    checkOutput("async_rst_trace_pc",    debug_wb_pc,               32'd0);
    checkOutput("async_rst_trace_wen",   {28'd0, debug_wb_rf_wen},  32'd0);
    checkOutput("async_rst_trace_wnum",  {27'd0, debug_wb_rf_wnum}, 32'd0);
    checkOutput("async_rst_trace_wdata", debug_wb_rf_wdata,         32'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(vecs[0], 1'b0, 1'b0);
    checkOutput("post_rst_add_wen",   {31'd0, bus.rf_wen},       32'd1);
    checkOutput("post_rst_stall_req", {31'd0, bus.wb_stall_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
